// File: rtl/instr_fetch_queue.sv
// Instruction fetch queue: issues one outstanding fetch at a time to instruction
// memory, buffers returned words with their PCs in a small FIFO, and presents the
// FIFO head to decode. A flush redirects fetch, empties the FIFO and discards any
// response still in flight.
module instr_fetch_queue #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  // instruction memory
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_valid,
  input  logic [31:0] imem_rdata,
  // pipeline control
  input  logic        stall,
  input  logic        flush,
  input  logic [31:0] redirect_pc,
  // decode-side view of the queue head
  output logic        id_valid,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc,
  output logic [31:0] id_pcplus4,
  output logic [6:0]  Op,
  output logic [2:0]  funct3,
  output logic        funct7b5
);

  localparam int unsigned       PtrW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned       CntW    = $clog2(DEPTH + 1);
  localparam logic [PtrW-1:0]   LastPtr = PtrW'(DEPTH - 1);
  localparam logic [CntW-1:0]   Full    = CntW'(DEPTH);
  localparam logic [31:0]       Nop     = 32'h0000_0013;

  typedef enum logic [1:0] {
    StFetch,
    StWait,
    StDiscard
  } state_e;

  state_e          state_q, state_d;
  logic [31:0]     fetch_pc_q, fetch_pc_d;
  logic [31:0]     req_pc_q, req_pc_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CntW-1:0] count_q, count_d;

  logic [31:0]     instr_mem [DEPTH];
  logic [31:0]     pc_mem    [DEPTH];

  logic            has_space;
  logic            head_valid;
  logic            issue;
  logic            push;
  logic            pop;

  // Low address bits of a redirect are forced to word alignment and never used.
  logic            unused_redirect_lsbs;
  assign unused_redirect_lsbs = ^redirect_pc[1:0];

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == LastPtr) ? '0 : p + 1'b1;
  endfunction

  // Handshake qualifiers; flush overrides every queue/fetch action in its cycle.
  always_comb begin
    has_space  = (count_q != Full);
    head_valid = (count_q != '0);
    // Gated by rst_n so no request is visible while reset is held.
    issue      = rst_n && (state_q == StFetch) && has_space && !flush;
    push       = (state_q == StWait) && imem_valid && !flush;
    pop        = head_valid && !stall && !flush;
  end

  // Next-state for fetch PC, request PC, FIFO pointers and occupancy.
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    req_pc_d   = req_pc_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    if (flush) begin
      fetch_pc_d = {redirect_pc[31:2], 2'b00};
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      count_d    = '0;
    end else begin
      if (issue) begin
        fetch_pc_d = fetch_pc_q + 32'd4;  // wraps naturally at 2^32
        req_pc_d   = fetch_pc_q;          // remembered for tagging the response
      end
      if (push) begin
        wr_ptr_d = ptr_inc(wr_ptr_q);
      end
      if (pop) begin
        rd_ptr_d = ptr_inc(rd_ptr_q);
      end
      unique case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  // Fetch FSM: one request in flight; DISCARD swallows a response made stale by flush.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StFetch: begin
        if (issue) begin
          state_d = StWait;
        end
      end
      StWait: begin
        if (imem_valid) begin
          state_d = StFetch;
        end else if (flush) begin
          state_d = StDiscard;
        end
      end
      StDiscard: begin
        if (imem_valid) begin
          state_d = StFetch;
        end
      end
      default: state_d = StFetch;
    endcase
  end

  // Control state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StFetch;
      fetch_pc_q <= RESET_PC;
      req_pc_q   <= RESET_PC;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      req_pc_q   <= req_pc_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
    end
  end

  // FIFO storage; contents are don't-care until counted valid, so no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      instr_mem[wr_ptr_q] <= imem_rdata;
      pc_mem[wr_ptr_q]    <= req_pc_q;
    end
  end

  // Memory-side and decode-side outputs, combinational from state and FIFO head.
  always_comb begin
    imem_req   = issue;
    imem_addr  = fetch_pc_q;
    id_valid   = head_valid;
    id_instr   = head_valid ? instr_mem[rd_ptr_q] : Nop;
    id_pc      = head_valid ? pc_mem[rd_ptr_q] : 32'h0000_0000;
    id_pcplus4 = id_pc + 32'd4;
    Op         = id_instr[6:0];
    funct3     = id_instr[14:12];
    funct7b5   = id_instr[30];
  end

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Directed bench for instr_fetch_queue (DEPTH=2, RESET_PC=0). Inputs change 1 ns
// after a rising edge; outputs are checked 1 ns after that.
module tb_instr_fetch_queue;

  logic        clk;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_valid;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        flush;
  logic [31:0] redirect_pc;
  logic        id_valid;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic [31:0] id_pcplus4;
  logic [6:0]  Op;
  logic [2:0]  funct3;
  logic        funct7b5;

  int checks = 0;
  int errors = 0;

  instr_fetch_queue #(
    .RESET_PC (32'h0000_0000),
    .DEPTH    (2)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_valid  (imem_valid),
    .imem_rdata  (imem_rdata),
    .stall       (stall),
    .flush       (flush),
    .redirect_pc (redirect_pc),
    .id_valid    (id_valid),
    .id_instr    (id_instr),
    .id_pc       (id_pc),
    .id_pcplus4  (id_pcplus4),
    .Op          (Op),
    .funct3      (funct3),
    .funct7b5    (funct7b5)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n       = 1'b0;
    imem_valid  = 1'b0;
    imem_rdata  = 32'h0;
    stall       = 1'b0;
    flush       = 1'b0;
    redirect_pc = 32'h0;

    // Reset values
    #2;
    chk("rst_id_valid", {31'h0, id_valid}, 32'h0);
    chk("rst_id_instr", id_instr, 32'h0000_0013);
    chk("rst_id_pc", id_pc, 32'h0);
    chk("rst_id_pcplus4", id_pcplus4, 32'h4);
    chk("rst_imem_req", {31'h0, imem_req}, 32'h0);

    // First request right after reset release
    #10;
    rst_n = 1'b1;
    #1;
    chk("req0", {31'h0, imem_req}, 32'h1);
    chk("req0_addr", imem_addr, 32'h0);

    // Waiting: no second request; response arrives next cycle
    tick();
    imem_valid = 1'b1;
    imem_rdata = 32'h0062_8233;
    #1;
    chk("wait_no_req", {31'h0, imem_req}, 32'h0);
    chk("wait_id_valid", {31'h0, id_valid}, 32'h0);

    // Head holds add at pc 0; next request to 4
    tick();
    imem_valid = 1'b0;
    #1;
    chk("h0_valid", {31'h0, id_valid}, 32'h1);
    chk("h0_pc", id_pc, 32'h0);
    chk("h0_pcplus4", id_pcplus4, 32'h4);
    chk("h0_instr", id_instr, 32'h0062_8233);
    chk("h0_op", {25'h0, Op}, 32'h33);
    chk("h0_funct3", {29'h0, funct3}, 32'h0);
    chk("h0_funct7b5", {31'h0, funct7b5}, 32'h0);
    chk("req1", {31'h0, imem_req}, 32'h1);
    chk("req1_addr", imem_addr, 32'h4);

    // Popped and request 4 outstanding
    tick();
    chk("popped_empty", {31'h0, id_valid}, 32'h0);
    imem_valid = 1'b1;
    imem_rdata = 32'h4062_8233;
    tick();
    imem_valid = 1'b0;
    stall      = 1'b1;
    #1;
    chk("h1_pc", id_pc, 32'h4);
    chk("h1_funct7b5", {31'h0, funct7b5}, 32'h1);
    chk("req2_addr", imem_addr, 32'h8);
    chk("req2", {31'h0, imem_req}, 32'h1);

    // Stalled: request 8 answered, queue fills to DEPTH
    tick();
    imem_valid = 1'b1;
    imem_rdata = 32'h0000_0093;
    tick();
    imem_valid = 1'b0;
    #1;
    chk("full_no_req", {31'h0, imem_req}, 32'h0);
    chk("full_head_pc", id_pc, 32'h4);
    tick();
    chk("full_no_req2", {31'h0, imem_req}, 32'h0);
    chk("full_valid", {31'h0, id_valid}, 32'h1);
    stall = 1'b0;

    // Release stall: pop in order, fetch resumes at 12
    tick();
    chk("drain_pc", id_pc, 32'h8);
    chk("drain_instr", id_instr, 32'h0000_0093);
    chk("resume_req", {31'h0, imem_req}, 32'h1);
    chk("resume_addr", imem_addr, 32'hC);
    tick();
    chk("drained", {31'h0, id_valid}, 32'h0);

    // Flush while waiting; stale response 3 cycles later is dropped
    flush       = 1'b1;
    redirect_pc = 32'h0000_0103;
    #1;
    chk("flush_no_req", {31'h0, imem_req}, 32'h0);
    tick();
    flush = 1'b0;
    #1;
    chk("discard_no_req", {31'h0, imem_req}, 32'h0);
    tick();
    imem_valid = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    tick();
    imem_valid = 1'b0;
    #1;
    chk("dropped_valid", {31'h0, id_valid}, 32'h0);
    chk("redirect_req", {31'h0, imem_req}, 32'h1);
    chk("redirect_addr", imem_addr, 32'h100);

    // Flush coincident with response and pop
    tick();
    imem_valid = 1'b1;
    imem_rdata = 32'h0010_0093;
    tick();
    imem_valid = 1'b0;
    stall      = 1'b1;
    #1;
    chk("h100_pc", id_pc, 32'h100);
    chk("req104", imem_addr, 32'h104);
    tick();
    stall       = 1'b0;
    imem_valid  = 1'b1;
    imem_rdata  = 32'h0020_0093;
    flush       = 1'b1;
    redirect_pc = 32'h0000_0200;
    #1;
    chk("cflush_no_req", {31'h0, imem_req}, 32'h0);
    tick();
    flush      = 1'b0;
    imem_valid = 1'b0;
    #1;
    chk("cflush_empty", {31'h0, id_valid}, 32'h0);
    chk("cflush_instr", id_instr, 32'h0000_0013);
    chk("cflush_req", {31'h0, imem_req}, 32'h1);
    chk("cflush_addr", imem_addr, 32'h200);

    // Reset while waiting with one entry queued
    tick();
    imem_valid = 1'b1;
    imem_rdata = 32'h00A0_0113;
    tick();
    imem_valid = 1'b0;
    stall      = 1'b1;
    tick();
    chk("pre_rst_pc", id_pc, 32'h200);
    chk("pre_rst_waiting", {31'h0, imem_req}, 32'h0);
    rst_n = 1'b0;
    stall = 1'b0;
    #1;
    chk("arst_valid", {31'h0, id_valid}, 32'h0);
    chk("arst_instr", id_instr, 32'h0000_0013);
    chk("arst_pc", id_pc, 32'h0);
    chk("arst_req", {31'h0, imem_req}, 32'h0);

    // Release; stray response in FETCH is ignored
    tick();
    rst_n      = 1'b1;
    imem_valid = 1'b1;
    imem_rdata = 32'h1111_1111;
    #1;
    chk("restart_req", {31'h0, imem_req}, 32'h1);
    chk("restart_addr", imem_addr, 32'h0);
    tick();
    imem_valid = 1'b1;
    imem_rdata = 32'h0000_0073;
    #1;
    chk("stray_ignored", {31'h0, id_valid}, 32'h0);
    tick();
    imem_valid = 1'b0;
    #1;
    chk("restart_pc", id_pc, 32'h0);
    chk("restart_instr", id_instr, 32'h0000_0073);

    // fetch_pc wraps from FFFF_FFFC to 0
    flush       = 1'b1;
    redirect_pc = 32'hFFFF_FFFF;
    tick();
    flush = 1'b0;
    #1;
    chk("wrap_addr", imem_addr, 32'hFFFF_FFFC);
    chk("wrap_req", {31'h0, imem_req}, 32'h1);
    tick();
    imem_valid = 1'b1;
    imem_rdata = 32'h0000_0013;
    tick();
    imem_valid = 1'b0;
    #1;
    chk("wrap_head_pc", id_pc, 32'hFFFF_FFFC);
    chk("wrap_pcplus4", id_pcplus4, 32'h0);
    chk("wrap_next_addr", imem_addr, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_fetch_queue.md
INSTR_FETCH_QUEUE -- requirements
Module: instr_fetch_queue

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: first fetch address after reset.
REQ-002 Parameter DEPTH, default 2: instruction queue entries; legal range 2..8.
REQ-003 clk  in  1  single clock, all state updates on rising edge.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 imem_req  out  1  fetch request, one-cycle pulse per request.
REQ-006 imem_addr  out  32  fetch address, valid when imem_req=1.
REQ-007 imem_valid  in  1  response strobe, one cycle, responses return in request order.
REQ-008 imem_rdata  in  32  instruction word, valid when imem_valid=1.
REQ-009 stall  in  1  decode stage not accepting this cycle.
REQ-010 flush  in  1  branch/jump redirect from execute.
REQ-011 redirect_pc  in  32  new fetch address, sampled when flush=1.
REQ-012 id_valid  out  1  queue head holds a real instruction.
REQ-013 id_instr  out  32  queue head instruction; 32'h0000_0013 (addi x0,x0,0) when id_valid=0.
REQ-014 id_pc / id_pcplus4  out  32 each  head PC and head PC+4; 0 / 4 when id_valid=0.
REQ-015 Op  out  7  id_instr[6:0], feeds control unit Op.
REQ-016 funct3  out  3  id_instr[14:12].
REQ-017 funct7b5  out  1  id_instr[30].

Function
REQ-018 The block SHALL hold fetch_pc (32 b), a DEPTH-entry FIFO of {instr, pc}, occupancy count (0..DEPTH) and state in {FETCH, WAIT, DISCARD}.
REQ-019 At most one request SHALL be outstanding at any time.
REQ-020 In FETCH with count < DEPTH and flush=0, the block SHALL assert imem_req with imem_addr=fetch_pc, add 4 to fetch_pc (32-bit wrap from 32'hFFFF_FFFC to 0), and enter WAIT.
REQ-021 In FETCH with count = DEPTH, imem_req SHALL stay 0 and state SHALL stay FETCH.
REQ-022 In WAIT on imem_valid=1 (flush=0), the block SHALL push {imem_rdata, address of that request} and enter FETCH; a new request SHALL NOT issue in that same cycle.
REQ-023 imem_valid in FETCH SHALL be ignored (protocol error, no push).
REQ-024 Pop SHALL occur when id_valid=1 and stall=0; head advances next cycle.
REQ-025 Simultaneous push and pop SHALL leave count unchanged and preserve order.
REQ-026 Push SHALL never occur at count = DEPTH (guaranteed by REQ-020 space check, since issue requires a free slot and pop only frees slots).
REQ-027 id_* and Op/funct3/funct7b5 SHALL be combinational from the FIFO head; zero-latency from entry becoming head.
REQ-028 Minimum latency imem_valid to id_valid SHALL be 1 cycle.
REQ-029 flush SHALL have priority over push, pop and issue: FIFO emptied (count=0), fetch_pc <= {redirect_pc[31:2], 2'b00}, no imem_req that cycle.
REQ-030 flush in WAIT with imem_valid=0 SHALL enter DISCARD; with imem_valid=1 the response SHALL be dropped and state SHALL enter FETCH.
REQ-031 In DISCARD the next imem_valid SHALL be dropped and state SHALL enter FETCH; no request issues in DISCARD.
REQ-032 flush in DISCARD SHALL update fetch_pc and remain in DISCARD (or go FETCH if imem_valid=1 same cycle); flush in FETCH SHALL stay in FETCH.
REQ-033 stall SHALL NOT block fetching until the FIFO is full.

Reset
REQ-034 rst_n=0 SHALL immediately force state=FETCH, fetch_pc=RESET_PC, count=0, imem_req=0, id_valid=0, id_instr=32'h0000_0013, id_pc=0, id_pcplus4=4.
REQ-035 Reset mid-request SHALL abandon the outstanding request; a response arriving after rst_n rises without a new request SHALL be ignored per REQ-023.
REQ-036 First imem_req SHALL assert in the first cycle after rst_n deasserts.

Verification
REQ-037 Reset release, 1-cycle memory, stall=0 -> requests to 0x0,0x4,0x8 every 2 cycles; id_valid with id_pc 0x0,0x4,0x8 in order.
REQ-038 imem_rdata=32'h0062_8233 (add) -> Op=7'h33, funct3=0, funct7b5=0 while head; 32'h4062_8233 -> funct7b5=1.
REQ-039 stall=1 held -> exactly DEPTH pushes, then imem_req stays 0; release stall -> pops in order, fetching resumes.
REQ-040 flush with redirect_pc=0x103 while WAIT, response 3 cycles later -> response dropped, id_valid=0, next imem_addr=0x100.
REQ-041 flush coincident with imem_valid and with a pop -> nothing pushed, count=0, next request to redirect address.
REQ-042 rst_n asserted while WAIT with FIFO holding 1 entry -> id_valid=0 same cycle, id_instr=0x13, restart at RESET_PC.
